// File: rtl/mem_ctl_sync_pkg.sv
// Shared definitions for the clocked SRAM bridge: FSM encoding,
// synchroniser depth and the legal wait-state range.
package mem_ctl_sync_pkg;

  // Access phases of the SRAM bridge
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_LATCH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Flops in each host-strobe synchroniser
  localparam int SYNC_DEPTH = 2;

  // Legal strobe length in clock cycles; the counter is sized for WAIT_MAX
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  // Keep an out-of-range wait count inside what the counter can express
  function automatic int clamp_wait(input int w);
    if (w < WAIT_MIN) return WAIT_MIN;
    if (w > WAIT_MAX) return WAIT_MAX;
    return w;
  endfunction

endpackage

// File: rtl/mem_ctl_sync_sync2.sv
// Multi-flop synchroniser for one active-low host strobe. Resets to 1 so
// a strobe is seen as inactive until it has been sampled SYNC_DEPTH times.
module mem_ctl_sync_sync2
  import mem_ctl_sync_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] stage;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '1;
    end else begin
      stage <= {stage[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/mem_ctl_sync.sv
// Clocked bridge from the microcontroller strobe bus to an asynchronous
// SRAM. Host strobes are synchronised, SRAM accesses run through
// SETUP / STROBE / LATCH phases, and a bank register supplies the upper
// SRAM address bits.
//
// Host handshake: the host drops ce_n together with exactly one of
// read_n / write_n (address, reg_sel and write data stable) and must hold
// the cycle while busy is high. Once busy falls the access is complete;
// on a read, data_bus carries the result until the host raises ce_n. The
// next cycle may start only after the controller has seen ce_n high.
module mem_ctl_sync
  import mem_ctl_sync_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int MEM_AW   = 17,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_n,
  input  logic              read_n,
  input  logic              write_n,
  input  logic              reg_sel,
  input  logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic [MEM_AW-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              ceh_n,
  output logic              ce2,
  output logic              we_n,
  output logic              oe_n
);

  localparam int BANK_W = MEM_AW - ADDR_W;
  localparam int WAIT_EFF = clamp_wait(WAIT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_EFF - 1);

  logic              ce_s;
  logic              rd_s;
  logic              wr_s;
  logic              req;
  logic              req_wr;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] bank_d;
  logic [DATA_W-1:0] bank_rd;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wdata;
  logic              is_wr;
  logic              mem_drive;

  mem_ctl_sync_sync2 u_sync_ce (.clk(clk), .reset(reset), .d(ce_n),    .q(ce_s));
  mem_ctl_sync_sync2 u_sync_rd (.clk(clk), .reset(reset), .d(read_n),  .q(rd_s));
  mem_ctl_sync_sync2 u_sync_wr (.clk(clk), .reset(reset), .d(write_n), .q(wr_s));

  // A cycle needs chip enable plus exactly one direction strobe; both
  // strobes low is treated as no request at all.
  assign req    = !ce_s && (rd_s != wr_s);
  assign req_wr = !wr_s;

  // Bank loads from the low data bits (zero-extended when the bus is
  // narrower); bank reads return the bank resized to the data width.
  assign bank_d  = BANK_W'(data_bus);
  assign bank_rd = DATA_W'(bank);

  // busy covers the acceptance cycle plus every SRAM phase
  assign busy = ((state == ST_IDLE) && req) ||
                (state inside {ST_SETUP, ST_STROBE, ST_LATCH});

  // Access sequencer: phases, wait counter, bank, latches and SRAM controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bank        <= '0;
      rdata       <= '0;
      wdata       <= '0;
      is_wr       <= 1'b0;
      mem_drive   <= 1'b0;
      mem_address <= '0;
      ceh_n       <= 1'b1;
      ce2         <= 1'b0;
      we_n        <= 1'b1;
      oe_n        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            is_wr <= req_wr;
            if (reg_sel) begin
              if (req_wr) begin
                bank <= bank_d;
              end else begin
                rdata <= bank_rd;
              end
              state <= ST_RELEASE;
            end else begin
              mem_address <= {bank, address_bus};
              if (req_wr) begin
                wdata <= data_bus;
              end
              mem_drive <= req_wr;
              ceh_n     <= 1'b0;
              ce2       <= 1'b1;
              state     <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          cnt   <= WAIT_LOAD;
          we_n  <= !is_wr;
          oe_n  <= is_wr;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            we_n <= 1'b1;
            oe_n <= 1'b1;
            // Sampled on the edge that ends the strobe, while oe_n is still low
            if (!is_wr) begin
              rdata <= mem_data;
            end
            state <= ST_LATCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LATCH: begin
          // Write data was held through this cycle; now release the SRAM
          mem_drive <= 1'b0;
          ceh_n     <= 1'b1;
          ce2       <= 1'b0;
          state     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (ce_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data goes to the host only while it is still asking for it
  assign data_bus = (!ce_n && !read_n && write_n && (state == ST_RELEASE)) ? rdata : 'z;
  assign mem_data = mem_drive ? wdata : 'z;

endmodule

// File: tb/tb_mem_ctl_sync.sv
// Bench for mem_ctl_sync: a default instance plus a WAIT_CYC=5 instance
// sharing the host strobes, an SRAM device model, and a reference model
// (bank value plus shadow memory) that predicts addresses and read data.
module tb_mem_ctl_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_n = 1'b1;
  logic       read_n = 1'b1;
  logic       write_n = 1'b1;
  logic       reg_sel = 1'b0;
  logic [6:0] address_bus = '0;
  logic       host_en = 1'b0;
  logic [7:0] host_val = '0;
  logic       mprobe_en = 1'b0;
  logic [7:0] mprobe = '0;

  wire  [7:0]  data_bus;
  wire  [7:0]  data_bus5;
  wire  [7:0]  mem_data;
  wire  [7:0]  mem_data5;
  logic        busy, busy5;
  logic [16:0] mem_address, mem_address5;
  logic        ceh_n, ce2, we_n, oe_n;
  logic        ceh_n5, ce2_5, we_n5, oe_n5;

  logic        sram_drv;
  logic [7:0]  sram_q = '0;

  assign data_bus  = host_en ? host_val : 'z;
  assign data_bus5 = host_en ? host_val : 'z;
  assign sram_drv  = !oe_n && !ceh_n && ce2;
  assign mem_data  = sram_drv ? sram_q : (mprobe_en ? mprobe : 'z);

  mem_ctl_sync dut (
    .clk(clk), .reset(reset), .ce_n(ce_n), .read_n(read_n), .write_n(write_n),
    .reg_sel(reg_sel), .address_bus(address_bus), .data_bus(data_bus), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .ceh_n(ceh_n), .ce2(ce2),
    .we_n(we_n), .oe_n(oe_n)
  );

  mem_ctl_sync #(.WAIT_CYC(5)) dut5 (
    .clk(clk), .reset(reset), .ce_n(ce_n), .read_n(read_n), .write_n(write_n),
    .reg_sel(reg_sel), .address_bus(address_bus), .data_bus(data_bus5), .busy(busy5),
    .mem_address(mem_address5), .mem_data(mem_data5), .ceh_n(ceh_n5), .ce2(ce2_5),
    .we_n(we_n5), .oe_n(oe_n5)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [9:0]  bank_m = '0;
  logic [7:0]  shadow [logic [16:0]];
  logic [7:0]  sram   [logic [16:0]];
  logic [7:0]  exp_q[$];

  // Power-up content of SRAM locations that were never written
  function automatic logic [7:0] fill(input logic [16:0] k);
    return k[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_read(input logic [16:0] k);
    return shadow.exists(k) ? shadow[k] : fill(k);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor + SRAM device ----------------
  int          we_cnt, oe_cnt, busy_cnt, we_cnt5, oe_cnt5, busy_cnt5;
  logic [16:0] seen_waddr, seen_raddr, seen_waddr5;
  logic [7:0]  seen_wdata;

  always @(negedge clk) begin
    if (!we_n) begin
      we_cnt++;
      seen_waddr = mem_address;
      seen_wdata = mem_data;
      if (!ceh_n && ce2) sram[mem_address] = mem_data;
    end
    if (!oe_n) begin
      oe_cnt++;
      seen_raddr = mem_address;
    end
    if (busy) busy_cnt++;
    if (!we_n5) begin
      we_cnt5++;
      seen_waddr5 = mem_address5;
    end
    if (!oe_n5) oe_cnt5++;
    if (busy5) busy_cnt5++;
    sram_q = sram.exists(mem_address) ? sram[mem_address] : fill(mem_address);
  end

  task automatic clear_counts();
    we_cnt = 0; oe_cnt = 0; busy_cnt = 0;
    we_cnt5 = 0; oe_cnt5 = 0; busy_cnt5 = 0;
  endtask

  // Drive two complementary values onto a bus; only an undriven DUT side
  // lets both through unchanged.
  task automatic check_released(input string tag, input bit on_mem);
    logic [7:0] p;
    p = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (on_mem) begin mprobe_en = 1'b1; mprobe = p; end
      else begin host_en = 1'b1; host_val = p; end
      #1;
      check_eq(tag, on_mem ? mem_data : data_bus, p);
      p = ~p;
    end
    mprobe_en = 1'b0;
    host_en = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic host_cycle(input bit wr, input bit sel, input logic [6:0] a, input logic [7:0] d);
    bit         ok;
    int         lat;
    logic [16:0] k;
    logic [7:0]  e;
    k = {bank_m, a};
    @(posedge clk); #2;
    clear_counts();
    address_bus = a; reg_sel = sel; host_en = wr; host_val = d;
    ce_n = 1'b0; write_n = !wr; read_n = wr;
    ok = 1'b0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; lat = i; break; end
    end
    check_eq("busy_rise", ok, 1);
    check_eq("detect_lat", lat, 2);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !busy5) begin ok = 1'b1; break; end
    end
    check_eq("busy_fall", ok, 1);
    if (!sel && wr) begin
      check_eq("wr_we_len", we_cnt, 2);
      check_eq("wr_oe_len", oe_cnt, 0);
      check_eq("wr_busy_len", busy_cnt, 5);
      check_eq("wr_addr", seen_waddr, k);
      check_eq("wr_data", seen_wdata, d);
      check_eq("w5_we_len", we_cnt5, 5);
      check_eq("w5_busy_len", busy_cnt5, 8);
      check_eq("w5_addr", seen_waddr5, k);
      shadow[k] = d;
    end else if (!sel && !wr) begin
      exp_q.push_back(ref_read(k));
      check_eq("rd_oe_len", oe_cnt, 2);
      check_eq("rd_we_len", we_cnt, 0);
      check_eq("rd_busy_len", busy_cnt, 5);
      check_eq("rd_addr", seen_raddr, k);
      check_eq("r5_oe_len", oe_cnt5, 5);
    end else begin
      check_eq("reg_we_len", we_cnt, 0);
      check_eq("reg_oe_len", oe_cnt, 0);
      check_eq("reg_busy_len", busy_cnt, 1);
      if (wr) bank_m = 10'(d);
      else exp_q.push_back(bank_m[7:0]);
    end
    if (!wr) begin
      e = exp_q.pop_front();
      check_eq(sel ? "reg_rdata" : "rd_data", data_bus, e);
    end
    ce_n = 1'b1; read_n = 1'b1; write_n = 1'b1; host_en = 1'b0; reg_sel = 1'b0;
    if (!wr) check_released("rd_bus_release", 1'b0);
    repeat (4) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    sram[17'h00010]   = 8'hC4;
    shadow[17'h00010] = 8'hC4;
    clear_counts();

    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ctrl", {ceh_n, ce2, we_n, oe_n}, 4'b1011);
    check_eq("rst_addr", mem_address, 17'h0);
    check_eq("rst5_ctrl", {ceh_n5, ce2_5, we_n5, oe_n5}, 4'b1011);
    check_released("rst_mem_release", 1'b1);
    check_released("rst_bus_release", 1'b0);
    reset = 1'b0;

    // Directed cases
    host_cycle(1'b1, 1'b0, 7'h05, 8'h73);
    host_cycle(1'b1, 1'b1, 7'h00, 8'h1A);
    host_cycle(1'b1, 1'b0, 7'h7F, 8'h99);
    check_eq("bank_addr", seen_waddr, 17'h00D7F);
    host_cycle(1'b0, 1'b1, 7'h00, 8'h00);
    host_cycle(1'b1, 1'b1, 7'h00, 8'h00);
    host_cycle(1'b0, 1'b0, 7'h10, 8'h00);
    host_cycle(1'b0, 1'b0, 7'h05, 8'h00);

    // Both direction strobes low: no access must start
    @(posedge clk); #2;
    clear_counts();
    ce_n = 1'b0; read_n = 1'b0; write_n = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("ill_busy", busy_cnt + busy_cnt5, 0);
    check_eq("ill_strobes", we_cnt + oe_cnt, 0);
    check_eq("ill_ctrl", {ceh_n, ce2}, 2'b10);
    ce_n = 1'b1; read_n = 1'b1; write_n = 1'b1;
    repeat (4) @(posedge clk);

    // Randomised traffic
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: host_cycle(1'b1, 1'b0, 7'($urandom), 8'($urandom));
        1: host_cycle(1'b0, 1'b0, 7'($urandom), 8'h00);
        2: host_cycle(1'b1, 1'b1, 7'h00, 8'($urandom_range(0, 3)));
        default: host_cycle(1'b0, 1'b1, 7'h00, 8'h00);
      endcase
    end

    // Reset in the middle of a write strobe
    @(posedge clk); #2;
    address_bus = 7'h22; host_en = 1'b1; host_val = 8'h3C;
    ce_n = 1'b0; write_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!we_n) begin ok = 1'b1; break; end
    end
    check_eq("rst_mid_strobe", ok, 1);
    shadow[{bank_m, 7'h22}] = 8'h3C;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_ctrl", {ceh_n, ce2, we_n, oe_n}, 4'b1011);
    check_eq("mid_rst_busy", {busy, busy5}, 2'b00);
    check_eq("mid_rst_we5", we_n5, 1);
    check_eq("mid_rst_addr", mem_address, 17'h0);
    check_released("mid_rst_mem", 1'b1);
    bank_m = '0;
    ce_n = 1'b1; write_n = 1'b1; host_en = 1'b0;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    host_cycle(1'b0, 1'b1, 7'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
